lcd_bus_arb: RTL and testbench
==============================

Name: lcd_bus_arb

Overview:
- Arbitrates the 16-bit 8080-style LCD write bus (lcd_dat/cs/rs/wr/rd/res) between a command requester and a pixel stream requester.
- The command requester is the init sequencer or the OSD/CPU register port. The pixel requester is the RGB pixel packer.
- Generates the power-on reset pulse, wr strobe timing and chip-select framing.
- Bounds pixel bursts so pending commands are never starved.

Parameters:
- WR_LO, 1, cycles lcd_wr (or lcd_rd) is held low per word (>=1).
- WR_HI, 1, cycles lcd_wr is held high after the low phase, data held (>=1).
- BURST_MAX, 64, maximum consecutive pixel words granted while cmd_req is pending (>=1).
- RES_CYC, 16, length in cycles of the lcd_res low pulse and of the post-reset wait.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_req  in  1  command word pending; level, held until cmd_ack
- cmd_rs  in  1  register-select value for the command word
- cmd_dat  in  16  command word
- cmd_ack  out  1  1-cycle pulse: command word accepted
- pix_vld  in  1  pixel word valid
- pix_dat  in  16  pixel word (RGB565); always sent with rs=1
- pix_rdy  out  1  pixel word accepted when pix_vld & pix_rdy
- sof  in  1  start-of-frame pulse; clears the burst counter
- busy  out  1  high when not in ARB state
- lcd_dat  out  16  LCD data bus
- lcd_cs  out  1  chip select, active low
- lcd_rs  out  1  register select
- lcd_wr  out  1  write strobe, active low
- lcd_rd  out  1  read strobe, active low
- lcd_res  out  1  LCD reset, active low

Behaviour:
- Reset (rst_n=0, async): state=RST_LO, lcd_res=0, lcd_cs=1, lcd_wr=1, lcd_rd=1, lcd_rs=0, lcd_dat=0, cmd_ack=0, pix_rdy=0, busy=1, bcnt=0, timer=0.
- Reset mid-transfer: everything is abandoned immediately; the reset values above apply. No partial strobe may persist.
- RST_LO: lcd_res=0 for RES_CYC cycles after rst_n deasserts, then lcd_res=1 and go to RST_WAIT.
- RST_WAIT: RES_CYC cycles, then go to ARB. cmd_ack and pix_rdy stay 0 in both reset states.
- ARB (single cycle): grant decision, combinational from state, cmd_req, pix_vld and bcnt.
  - cmd wins if cmd_req & (bcnt==0 | bcnt==BURST_MAX | !pix_vld).
  - Otherwise pix wins if pix_vld.
  - cmd_ack and pix_rdy are mutually exclusive and are only asserted in ARB.
- On a grant edge:
  - Latch lcd_dat, lcd_rs (cmd_rs, or 1 for pix), lcd_cs=0, lcd_wr=0; go to LO.
  - A cmd grant clears bcnt; a pix grant increments bcnt (saturating at BURST_MAX).
- No grant in ARB: lcd_cs=1, lcd_wr=1, bcnt=0.
- LO: WR_LO cycles with wr=0, then go to HI (wr=1, data and rs held).
- HI: WR_HI cycles, then return to ARB. cs stays low through ARB if that ARB grants again.
- Word period is 1+WR_LO+WR_HI cycles; 3 cycles at defaults.
- lcd_wr must rise while lcd_dat is stable: data changes only at grant edges.
- sof=1 sets bcnt=0 on the next edge. If sof coincides with a pix grant, bcnt=1.
- bcnt width is clog2(BURST_MAX+1).
- Timers count down from param-1; WR_LO=WR_HI=1 must give exactly 1 cycle each.

Optional Feature:
- Macro: LCD_BUS_ARB_RD_EN.
- With the macro, these ports are added:
  - cmd_rd in 1 (sampled with cmd_req)
  - lcd_dat_i in 16
  - lcd_dat_oe out 1 (reset 1)
  - cmd_rdat out 16 (reset 0)
  - cmd_rvld out 1 (reset 0)
- A cmd grant with cmd_rd=1 behaves as follows:
  - lcd_dat_oe=0, lcd_rd low instead of lcd_wr for WR_LO cycles.
  - lcd_dat_i is sampled into cmd_rdat on the last LO cycle.
  - cmd_rvld pulses for 1 cycle on the first HI cycle.
  - lcd_dat_oe returns to 1 at the next grant edge.
- Without the macro: these ports are absent, lcd_rd is constant 1, and the bus is always driven.

Test Plan:
- Reset: rst_n low 5 cycles then high, RES_CYC=16 -> lcd_res low 16 cycles after release, high thereafter; busy falls 32 cycles after release; cs/wr held 1 throughout.
- Single command: cmd_req with rs=0, dat=16'h0022 -> cmd_ack for 1 cycle; next cycle cs=0, rs=0, dat=0022, wr=0 for 1 cycle, then high 1 cycle; cs returns 1 in the following ARB.
- Simultaneous: cmd_req and pix_vld together at bcnt=0 -> cmd granted first, pixel granted 3 cycles later.
- Burst limit: BURST_MAX=4, pix_vld continuous, cmd_req raised during the first pixel -> exactly 4 pixels (rs=1), then the command, then pixels resume.
- Throughput: 100 pixels with pix_vld stuck high, no cmd -> pix_rdy every 3rd cycle, cs low continuously, 300 cycles total.
- Mid-transfer reset: assert rst_n low during LO -> wr=1, cs=1, lcd_res=0 in the same cycle (async); with RD_EN, a read of lcd_dat_i=16'hA5A5 -> cmd_rdat=A5A5, cmd_rvld 1 pulse, lcd_wr stays 1.

Source files
------------

// File: rtl/lcd_bus_arb.sv
// Arbitrates a 16-bit 8080-style LCD bus between a command port and a pixel stream, with power-on reset pulse.
// Define LCD_BUS_ARB_RD_EN to add read cycles on the command port.
module lcd_bus_arb #(
   parameter int WR_LO     = 1,
   parameter int WR_HI     = 1,
   parameter int BURST_MAX = 64,
   parameter int RES_CYC   = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_req,
   input  logic        cmd_rs,
   input  logic [15:0] cmd_dat,
   output logic        cmd_ack,
   input  logic        pix_vld,
   input  logic [15:0] pix_dat,
   output logic        pix_rdy,
   input  logic        sof,
   output logic        busy,
   output logic [15:0] lcd_dat,
   output logic        lcd_cs,
   output logic        lcd_rs,
   output logic        lcd_wr,
   output logic        lcd_rd,
`ifdef LCD_BUS_ARB_RD_EN
   input  logic        cmd_rd,
   input  logic [15:0] lcd_dat_i,
   output logic        lcd_dat_oe,
   output logic [15:0] cmd_rdat,
   output logic        cmd_rvld,
`endif
   output logic        lcd_res
);
   localparam int T_WR  = (WR_LO > WR_HI) ? WR_LO : WR_HI;
   localparam int T_MAX = (RES_CYC > T_WR) ? RES_CYC : T_WR;
   localparam int TW    = $clog2(T_MAX + 1);
   localparam int BW    = $clog2(BURST_MAX + 1);
   localparam logic [TW-1:0] T_RES = TW'(RES_CYC - 1);
   localparam logic [TW-1:0] T_LO  = TW'(WR_LO - 1);
   localparam logic [TW-1:0] T_HI  = TW'(WR_HI - 1);
   localparam logic [BW-1:0] B_MAX = BW'(BURST_MAX);

   typedef enum logic [2:0] {
      S_RST_LO,
      S_RST_WAIT,
      S_ARB,
      S_LO,
      S_HI
   } state_t;

   state_t        r_state, w_state_next;
   logic [TW-1:0] r_timer, w_timer_next;
   logic [BW-1:0] r_bcnt, w_bcnt_next;
   logic [15:0]   r_lcd_dat, w_lcd_dat_next;
   logic          r_lcd_cs, w_lcd_cs_next;
   logic          r_lcd_rs, w_lcd_rs_next;
   logic          r_lcd_wr, w_lcd_wr_next;
   logic          r_lcd_res, w_lcd_res_next;
   logic          w_cmd_win, w_pix_win, w_grant, w_is_rd, w_lo_done;

   // A pending command beats pixels at burst start, at the burst cap, or when no pixel is offered.
   assign w_cmd_win = (r_state == S_ARB) && cmd_req &&
                      ((r_bcnt == '0) || (r_bcnt == B_MAX) || !pix_vld);
   assign w_pix_win = (r_state == S_ARB) && !w_cmd_win && pix_vld;
   assign w_grant   = w_cmd_win || w_pix_win;
   assign w_lo_done = (r_state == S_LO) && (r_timer == '0);

   assign cmd_ack = w_cmd_win;
   assign pix_rdy = w_pix_win;
   assign busy    = (r_state != S_ARB);
   assign lcd_dat = r_lcd_dat;
   assign lcd_cs  = r_lcd_cs;
   assign lcd_rs  = r_lcd_rs;
   assign lcd_wr  = r_lcd_wr;
   assign lcd_res = r_lcd_res;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_RST_LO;
         r_timer   <= '0;
         r_bcnt    <= '0;
         r_lcd_dat <= '0;
         r_lcd_cs  <= 1'b1;
         r_lcd_rs  <= 1'b0;
         r_lcd_wr  <= 1'b1;
         r_lcd_res <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_timer   <= w_timer_next;
         r_bcnt    <= w_bcnt_next;
         r_lcd_dat <= w_lcd_dat_next;
         r_lcd_cs  <= w_lcd_cs_next;
         r_lcd_rs  <= w_lcd_rs_next;
         r_lcd_wr  <= w_lcd_wr_next;
         r_lcd_res <= w_lcd_res_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_timer_next   = r_timer;
      w_bcnt_next    = sof ? '0 : r_bcnt;
      w_lcd_dat_next = r_lcd_dat;
      w_lcd_cs_next  = r_lcd_cs;
      w_lcd_rs_next  = r_lcd_rs;
      w_lcd_wr_next  = r_lcd_wr;
      w_lcd_res_next = r_lcd_res;
      case (r_state)
         S_RST_LO: begin
            if (r_timer == T_RES) begin
               w_state_next   = S_RST_WAIT;
               w_timer_next   = '0;
               w_lcd_res_next = 1'b1;
            end else begin
               w_timer_next = r_timer + 1'b1;
            end
         end
         S_RST_WAIT: begin
            if (r_timer == T_RES) begin
               w_state_next = S_ARB;
               w_timer_next = '0;
            end else begin
               w_timer_next = r_timer + 1'b1;
            end
         end
         S_ARB: begin
            if (w_grant) begin
               w_state_next   = S_LO;
               w_timer_next   = T_LO;
               w_lcd_dat_next = w_cmd_win ? cmd_dat : pix_dat;
               w_lcd_rs_next  = w_cmd_win ? cmd_rs : 1'b1;
               w_lcd_cs_next  = 1'b0;
               w_lcd_wr_next  = w_is_rd;
               if (w_cmd_win)
                  w_bcnt_next = '0;
               else if (sof)
                  w_bcnt_next = BW'(1);
               else if (r_bcnt != B_MAX)
                  w_bcnt_next = r_bcnt + 1'b1;
               else
                  w_bcnt_next = r_bcnt;
            end else begin
               w_lcd_cs_next = 1'b1;
               w_lcd_wr_next = 1'b1;
               w_bcnt_next   = '0;
            end
         end
         S_LO: begin
            if (r_timer == '0) begin
               w_state_next  = S_HI;
               w_timer_next  = T_HI;
               w_lcd_wr_next = 1'b1;
            end else begin
               w_timer_next = r_timer - 1'b1;
            end
         end
         S_HI: begin
            if (r_timer == '0)
               w_state_next = S_ARB;
            else
               w_timer_next = r_timer - 1'b1;
         end
         default: w_state_next = S_RST_LO;
      endcase
   end

`ifdef LCD_BUS_ARB_RD_EN
   logic        r_is_rd, r_lcd_rd, r_dat_oe, r_rvld;
   logic [15:0] r_rdat;

   assign w_is_rd    = w_cmd_win && cmd_rd;
   assign lcd_rd     = r_lcd_rd;
   assign lcd_dat_oe = r_dat_oe;
   assign cmd_rdat   = r_rdat;
   assign cmd_rvld   = r_rvld;

   // Read data is captured on the last low cycle of rd, and the bus stays released until the next grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_is_rd  <= 1'b0;
         r_lcd_rd <= 1'b1;
         r_dat_oe <= 1'b1;
         r_rvld   <= 1'b0;
         r_rdat   <= '0;
      end else begin
         r_rvld <= 1'b0;
         if (w_grant) begin
            r_is_rd  <= w_is_rd;
            r_lcd_rd <= !w_is_rd;
            r_dat_oe <= !w_is_rd;
         end else if (w_lo_done) begin
            r_lcd_rd <= 1'b1;
            if (r_is_rd) begin
               r_rdat <= lcd_dat_i;
               r_rvld <= 1'b1;
            end
         end
      end
   end
`else
   logic w_unused;
   assign w_is_rd  = 1'b0;
   assign lcd_rd   = 1'b1;
   assign w_unused = w_lo_done;
`endif

endmodule

// File: tb/tb_lcd_bus_arb.sv
// Self-checking bench for lcd_bus_arb: vector table, directed burst/throughput/reset sequences and a randomized model run.
module tb_lcd_bus_arb;
   localparam int WL  = 1;
   localparam int WH  = 1;
   localparam int BM  = 4;
   localparam int RC  = 16;
   localparam int PER = 1 + WL + WH;
   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_req, cmd_rs, cmd_ack;
   logic [15:0] cmd_dat;
   logic        pix_vld, pix_rdy, sof, busy;
   logic [15:0] pix_dat;
   logic [15:0] lcd_dat;
   logic        lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_res;
`ifdef LCD_BUS_ARB_RD_EN
   logic        cmd_rd, lcd_dat_oe, cmd_rvld;
   logic [15:0] lcd_dat_i, cmd_rdat;
`endif

   lcd_bus_arb #(.WR_LO(WL), .WR_HI(WH), .BURST_MAX(BM), .RES_CYC(RC)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_req(cmd_req), .cmd_rs(cmd_rs), .cmd_dat(cmd_dat), .cmd_ack(cmd_ack),
      .pix_vld(pix_vld), .pix_dat(pix_dat), .pix_rdy(pix_rdy),
      .sof(sof), .busy(busy),
      .lcd_dat(lcd_dat), .lcd_cs(lcd_cs), .lcd_rs(lcd_rs), .lcd_wr(lcd_wr), .lcd_rd(lcd_rd),
`ifdef LCD_BUS_ARB_RD_EN
      .cmd_rd(cmd_rd), .lcd_dat_i(lcd_dat_i), .lcd_dat_oe(lcd_dat_oe),
      .cmd_rdat(cmd_rdat), .cmd_rvld(cmd_rvld),
`endif
      .lcd_res(lcd_res)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called just after a posedge with rst_n low; releases reset and checks the power-on sequence.
   task automatic reset_release();
      rst_n   = 1'b1;
      cmd_req = 1'b1;
      pix_vld = 1'b1;
      for (int k = 0; k <= 2 * RC; k++) begin
         @(negedge clk);
         check("rst_res", lcd_res, (k >= RC));
         check("rst_busy", busy, (k < 2 * RC));
         check("rst_cs_wr", {lcd_cs, lcd_wr, lcd_rd}, 3'b111);
         check("rst_grants", {cmd_ack, pix_rdy}, 2'b00);
         tick();
         if (k == 2 * RC - 1) begin
            cmd_req = 1'b0;
            pix_vld = 1'b0;
         end
      end
      $display("reset sequence done t=%0t", $time);
   endtask

   typedef struct {
      logic cr; logic crs; logic [15:0] cd; logic pv; logic [15:0] pd;
      logic ack; logic rdy; logic cs; logic wr; logic rs; logic [15:0] dat; logic busy;
   } vec_t;
   vec_t tbl [13];

   // Directed-sequence state
   string order;
   int    n_pix_before, n_pix_after, bad_rs, tp_bad, cs_bad, tp_cnt;
   logic  cmd_seen, prev_pix, prev_cmd;

   // Reference model state for the randomized run
   int          cyc, next_arb, last_grant, m_run, d;
   logic        m_cs, m_rs, cw, pw, is_arb, exp_wr;
   logic [15:0] m_dat;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{H, L, 16'h0022, L, 16'h0000, H, L, H, H, L, 16'h0000, L};
      tbl[1]  = '{L, L, 16'h0000, L, 16'h0000, L, L, L, L, L, 16'h0022, H};
      tbl[2]  = '{L, L, 16'h0000, L, 16'h0000, L, L, L, H, L, 16'h0022, H};
      tbl[3]  = '{L, L, 16'h0000, L, 16'h0000, L, L, L, H, L, 16'h0022, L};
      tbl[4]  = '{L, L, 16'h0000, L, 16'h0000, L, L, H, H, L, 16'h0022, L};
      tbl[5]  = '{H, H, 16'h1234, H, 16'hF800, H, L, H, H, L, 16'h0022, L};
      tbl[6]  = '{L, L, 16'h0000, H, 16'hF800, L, L, L, L, H, 16'h1234, H};
      tbl[7]  = '{L, L, 16'h0000, H, 16'hF800, L, L, L, H, H, 16'h1234, H};
      tbl[8]  = '{L, L, 16'h0000, H, 16'hF800, L, H, L, H, H, 16'h1234, L};
      tbl[9]  = '{L, L, 16'h0000, L, 16'h0000, L, L, L, L, H, 16'hF800, H};
      tbl[10] = '{L, L, 16'h0000, L, 16'h0000, L, L, L, H, H, 16'hF800, H};
      tbl[11] = '{L, L, 16'h0000, L, 16'h0000, L, L, L, H, H, 16'hF800, L};
      tbl[12] = '{L, L, 16'h0000, L, 16'h0000, L, L, H, H, H, 16'hF800, L};

      rst_n = 1'b0; cmd_req = 1'b0; cmd_rs = 1'b0; cmd_dat = '0;
      pix_vld = 1'b0; pix_dat = '0; sof = 1'b0;
`ifdef LCD_BUS_ARB_RD_EN
      cmd_rd = 1'b0; lcd_dat_i = '0;
`endif
      @(negedge clk);
      check("por_res", lcd_res, 1'b0);
      check("por_cs_wr", {lcd_cs, lcd_wr, lcd_rs}, 3'b110);
      check("por_busy", busy, 1'b1);
      check("por_dat", lcd_dat, 16'h0000);
      repeat (5) @(posedge clk);
      #1;
      reset_release();

      // Cycle-by-cycle vectors: single command, then simultaneous cmd+pix at bcnt=0
      for (int i = 0; i < 13; i++) begin
         cmd_req = tbl[i].cr; cmd_rs = tbl[i].crs; cmd_dat = tbl[i].cd;
         pix_vld = tbl[i].pv; pix_dat = tbl[i].pd;
         @(negedge clk);
         $display("vec %0d ack=%b rdy=%b cs=%b wr=%b rs=%b dat=%h busy=%b",
                  i, cmd_ack, pix_rdy, lcd_cs, lcd_wr, lcd_rs, lcd_dat, busy);
         check("vec_ack", cmd_ack, tbl[i].ack);
         check("vec_rdy", pix_rdy, tbl[i].rdy);
         check("vec_cs", lcd_cs, tbl[i].cs);
         check("vec_wr", lcd_wr, tbl[i].wr);
         check("vec_rs", lcd_rs, tbl[i].rs);
         check("vec_dat", lcd_dat, tbl[i].dat);
         check("vec_busy", busy, tbl[i].busy);
         tick();
      end

      // Burst cap: command raised during the first pixel waits for exactly BM pixels
      order = ""; n_pix_before = 0; n_pix_after = 0; bad_rs = 0;
      cmd_seen = 1'b0; prev_pix = 1'b0; prev_cmd = 1'b0;
      cmd_req = 1'b0; pix_vld = 1'b1; pix_dat = 16'h0100;
      for (int c = 0; c < 80 && n_pix_after < 2; c++) begin
         @(negedge clk);
         if (prev_pix && (lcd_rs !== 1'b1 || lcd_wr !== 1'b0)) bad_rs++;
         if (prev_cmd) begin
            check("burst_cmd_rs", lcd_rs, 1'b0);
            check("burst_cmd_dat", lcd_dat, 16'h002C);
         end
         prev_pix = pix_rdy;
         prev_cmd = cmd_ack;
         if (cmd_ack && pix_rdy) bad_rs++;
         if (pix_rdy) begin
            order = {order, "P"};
            if (cmd_seen) n_pix_after++; else n_pix_before++;
         end
         if (cmd_ack) begin
            order = {order, "C"};
            cmd_seen = 1'b1;
         end
         tick();
         if (prev_pix) pix_dat = pix_dat + 16'd1;
         if (prev_cmd) cmd_req = 1'b0;
         else if (prev_pix && !cmd_seen && !cmd_req) begin
            cmd_req = 1'b1; cmd_rs = 1'b0; cmd_dat = 16'h002C;
         end
      end
      $display("burst order %s", order);
      check("burst_cmd_seen", cmd_seen, 1'b1);
      check("burst_pix_before_cmd", n_pix_before, BM);
      check("burst_pix_resume", n_pix_after, 2);
      check("burst_pix_rs_excl", bad_rs, 0);
      pix_vld = 1'b0;
      repeat (4) tick();

      // Throughput: 100 back-to-back pixels
      tp_bad = 0; cs_bad = 0; tp_cnt = 0;
      pix_vld = 1'b1;
      for (int i = 0; i < 300; i++) begin
         pix_dat = 16'(i);
         @(negedge clk);
         if (pix_rdy !== ((i % PER) == 0)) tp_bad++;
         if (pix_rdy === 1'b1) tp_cnt++;
         if (i >= 1 && lcd_cs !== 1'b0) cs_bad++;
         tick();
         if (i == 297) pix_vld = 1'b0;
      end
      $display("throughput: %0d pixels in 300 cycles", tp_cnt);
      check("tp_count", tp_cnt, 100);
      check("tp_pattern", tp_bad, 0);
      check("tp_cs_low", cs_bad, 0);

`ifdef LCD_BUS_ARB_RD_EN
      cmd_req = 1'b1; cmd_rd = 1'b1; cmd_rs = 1'b1; cmd_dat = 16'hBEEF; lcd_dat_i = 16'hA5A5;
      @(negedge clk);
      check("rd_ack", cmd_ack, 1'b1);
      tick();
      cmd_req = 1'b0; cmd_rd = 1'b0;
      @(negedge clk);
      check("rd_lo_strobes", {lcd_rd, lcd_wr, lcd_dat_oe, lcd_cs}, 4'b0100);
      tick();
      lcd_dat_i = 16'h0000;
      @(negedge clk);
      check("rd_rvld", cmd_rvld, 1'b1);
      check("rd_rdat", cmd_rdat, 16'hA5A5);
      check("rd_hi_strobes", {lcd_rd, lcd_wr}, 2'b11);
      tick();
      @(negedge clk);
      check("rd_rvld_pulse", cmd_rvld, 1'b0);
      check("rd_oe_held", lcd_dat_oe, 1'b0);
      $display("read cycle rdat=%h", cmd_rdat);
      tick();
`endif

      // Reset asserted in the middle of a write strobe
      cmd_req = 1'b1; cmd_rs = 1'b1; cmd_dat = 16'h5555;
      @(negedge clk);
      check("mid_ack", cmd_ack, 1'b1);
      tick();
      cmd_req = 1'b0;
      check("mid_wr_low_before", lcd_wr, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("mid_wr", lcd_wr, 1'b1);
      check("mid_cs", lcd_cs, 1'b1);
      check("mid_res", lcd_res, 1'b0);
      check("mid_busy_dat", {busy, lcd_dat}, 17'h10000);
`ifdef LCD_BUS_ARB_RD_EN
      check("mid_oe", lcd_dat_oe, 1'b1);
`endif
      $display("mid-transfer reset applied t=%0t", $time);
      repeat (5) @(posedge clk);
      #1;
      reset_release();

      // Randomized run against a timeline model of grants
      cyc = 0; next_arb = 0; last_grant = -100; m_run = 0;
      m_cs = 1'b1; m_rs = 1'b0; m_dat = 16'h0000;
      cmd_req = 1'b0; pix_vld = 1'b0; sof = 1'b0;
      for (int n = 0; n < 1500; n++) begin
         @(negedge clk);
         is_arb = (cyc == next_arb);
         cw = is_arb && cmd_req && (m_run == 0 || m_run == BM || !pix_vld);
         pw = is_arb && !cw && pix_vld;
         d = cyc - last_grant;
         exp_wr = !(d >= 1 && d <= WL);
         check("r_ack", cmd_ack, cw);
         check("r_rdy", pix_rdy, pw);
         check("r_busy", busy, !is_arb);
         check("r_cs", lcd_cs, m_cs);
         check("r_wr", lcd_wr, exp_wr);
         check("r_rs", lcd_rs, m_rs);
         check("r_dat", lcd_dat, m_dat);
         tick();
         if (cw || pw) begin
            last_grant = cyc;
            next_arb = cyc + PER;
            m_cs = 1'b0;
            m_dat = cw ? cmd_dat : pix_dat;
            m_rs = cw ? cmd_rs : 1'b1;
            if (cw) m_run = 0;
            else if (sof) m_run = 1;
            else m_run = (m_run + 1 > BM) ? BM : m_run + 1;
            $display("rand t=%0d %s rs=%b dat=%h run=%0d", cyc, cw ? "cmd" : "pix", m_rs, m_dat, m_run);
         end else if (is_arb) begin
            next_arb = cyc + 1;
            m_cs = 1'b1;
            m_run = 0;
         end else if (sof) begin
            m_run = 0;
         end
         cyc++;
         if (cw) cmd_req = 1'b0;
         if (!cmd_req && ($urandom % 4) == 0) begin
            cmd_req = 1'b1;
            cmd_rs = 1'($urandom);
            cmd_dat = 16'($urandom);
         end
         pix_vld = (($urandom % 10) < 7);
         pix_dat = 16'($urandom);
         sof = (($urandom % 25) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
